// File: rtl/spr_pkg.sv
// Shared types and constants for the sprite evaluation / pattern fetch block.
// Field positions of the packed render word are defined here so producer and consumers agree.
package spr_pkg;

    localparam int N_SLOTS = 8;
    localparam int N_OAM   = 64;

    localparam logic [7:0] Y_HIDE = 8'hF0;

    localparam int LO_LSB    = 0;
    localparam int LO_MSB    = 7;
    localparam int HI_LSB    = 8;
    localparam int HI_MSB    = 15;
    localparam int X_LSB     = 16;
    localparam int X_MSB     = 23;
    localparam int PAL_LSB   = 24;
    localparam int PAL_MSB   = 25;
    localparam int PRIO_LSB  = 29;
    localparam int PRIO_MSB  = 29;
    localparam int HFLIP_LSB = 30;
    localparam int HFLIP_MSB = 30;

    // Word loaded into a slot that holds no sprite: transparent patterns, X parked off-screen.
    localparam logic [31:0] EMPTY_WORD = 32'h00FF_0000;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SCAN_Y   = 4'd1,
        ST_SCAN_T   = 4'd2,
        ST_SCAN_A   = 4'd3,
        ST_SCAN_X   = 4'd4,
        ST_FETCH_LO = 4'd5,
        ST_FETCH_HI = 4'd6,
        ST_LOAD     = 4'd7,
        ST_DONE     = 4'd8
    } spr_state_e;

    typedef struct packed {
        logic [2:0] row;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
    } spr_ent_t;

    function automatic logic [31:0] pack_word(input spr_ent_t e, input logic [7:0] lo,
                                              input logic [7:0] hi);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[LO_MSB:LO_LSB]       = lo;
        w[HI_MSB:HI_LSB]       = hi;
        w[X_MSB:X_LSB]         = e.x;
        w[PAL_MSB:PAL_LSB]     = e.attr[1:0];
        w[PRIO_MSB:PRIO_LSB]   = e.attr[5];
        w[HFLIP_MSB:HFLIP_LSB] = e.attr[6];
        return w;
    endfunction

endpackage

// File: rtl/spr_scan.sv
// OAM scanner: walks all entries, hit-tests Y against the latched line and builds the
// secondary list of up to N_SLOTS sprites. Overflow detection is built with SPR_OVF_EN.
module spr_scan
    import spr_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               line_in,
    output logic [7:0]               oam_addr,
    input  logic [7:0]               oam_data,
    output logic                     scan_done,
    output logic [3:0]               hit_cnt,
    output spr_ent_t [N_SLOTS-1:0]   list,
    output logic                     overflow
);

    localparam logic [5:0] LAST_IDX = 6'(N_OAM - 1);

    spr_state_e             state_q, state_d;
    logic [5:0]             idx_q, idx_d;
    logic                   ph_q, ph_d;
    logic [2:0]             diff_q, diff_d;
    logic [2:0]             row_q, row_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [7:0]             line_q, line_d;
    logic [7:0]             tile_q, tile_d;
    logic [7:0]             attr_q, attr_d;
    spr_ent_t [N_SLOTS-1:0] list_q, list_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             oam_addr_q, oam_addr_d;
    logic                   done_q, done_d;

    logic [7:0] diff_s;
    logic       hit_s;
    logic       full_s;
    logic       stop_s;
    logic       last_s;

    assign diff_s = line_q - oam_data;
    assign hit_s  = (diff_s < 8'd8) && (oam_data < Y_HIDE);
    assign full_s = cnt_q[3];

`ifdef SPR_OVF_EN
    assign stop_s = 1'b0;
`else
    // Without overflow reporting there is nothing to learn past the last free slot.
    assign stop_s = (cnt_q == 4'd7);
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 6'd0;
            ph_q       <= 1'b0;
            diff_q     <= 3'd0;
            row_q      <= 3'd0;
            cnt_q      <= 4'd0;
            line_q     <= 8'd0;
            tile_q     <= 8'd0;
            attr_q     <= 8'd0;
            list_q     <= '0;
            ovf_q      <= 1'b0;
            oam_addr_q <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ph_q       <= ph_d;
            diff_q     <= diff_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            tile_q     <= tile_d;
            attr_q     <= attr_d;
            list_q     <= list_d;
            ovf_q      <= ovf_d;
            oam_addr_q <= oam_addr_d;
            done_q     <= done_d;
        end
    end

    // Next-state and secondary-list capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        diff_d  = diff_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        tile_d  = tile_q;
        attr_d  = attr_q;
        list_d  = list_q;
        last_s  = 1'b0;
        if (start) begin
            state_d = ST_SCAN_Y;
            idx_d   = 6'd0;
            ph_d    = 1'b0;
            cnt_d   = 4'd0;
            line_d  = line_in;
            list_d  = '0;
        end else begin
            case (state_q)
                ST_SCAN_Y: begin
                    // ph 0 issues the Y address, ph 1 sees Y and decides.
                    if (!ph_q) begin
                        ph_d = 1'b1;
                    end else if (hit_s && !full_s) begin
                        state_d = ST_SCAN_T;
                        diff_d  = diff_s[2:0];
                        ph_d    = 1'b0;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        ph_d    = 1'b0;
                        last_s  = 1'b1;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        ph_d  = 1'b0;
                    end
                end
                ST_SCAN_T: begin
                    tile_d  = oam_data;
                    state_d = ST_SCAN_A;
                end
                ST_SCAN_A: begin
                    attr_d  = oam_data;
                    row_d   = oam_data[7] ? ~diff_q : diff_q;
                    state_d = ST_SCAN_X;
                end
                ST_SCAN_X: begin
                    list_d[cnt_q[2:0]] = {row_q, tile_q, attr_q, oam_data};
                    cnt_d = cnt_q + 4'd1;
                    if ((idx_q == LAST_IDX) || stop_s) begin
                        state_d = ST_IDLE;
                        last_s  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = ST_SCAN_Y;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Registered outputs: OAM address for the coming cycle, completion pulse, overflow.
    always_comb begin
        done_d = last_s;
        case (state_d)
            ST_SCAN_Y: oam_addr_d = {idx_d, 1'b0, ph_d};
            ST_SCAN_T: oam_addr_d = {idx_d, 2'b10};
            ST_SCAN_A: oam_addr_d = {idx_d, 2'b11};
            ST_SCAN_X: oam_addr_d = {idx_d, 2'b11};
            default:   oam_addr_d = 8'h00;
        endcase
`ifdef SPR_OVF_EN
        if (start) begin
            ovf_d = 1'b0;
        end else if ((state_q == ST_SCAN_Y) && ph_q && hit_s && full_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
`else
        ovf_d = 1'b0;
`endif
    end

    assign oam_addr  = oam_addr_q;
    assign scan_done = done_q;
    assign hit_cnt   = cnt_q;
    assign list      = list_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/spr_fetch.sv
// Per-scanline sprite evaluation and pattern fetch feeding the eight render buffers.
// Define SPR_OVF_EN to report more-than-eight-sprite lines on overflow.
module spr_fetch
    import spr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 line_start,
    input  logic [7:0]           next_line,
    input  logic                 pat_sel,
    output logic [7:0]           oam_addr,
    input  logic [7:0]           oam_data,
    output logic                 pat_req,
    output logic [12:0]          pat_addr,
    input  logic                 pat_ack,
    input  logic [7:0]           pat_data,
    output logic [31:0]          rend_buf,
    output logic [N_SLOTS-1:0]   rend_load,
    output logic [N_SLOTS-1:0]   spr_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    spr_state_e          state_q, state_d;
    logic [2:0]          slot_q, slot_d;
    logic [7:0]          lo_q, lo_d;
    logic                sel_q, sel_d;
    logic                pat_req_q, pat_req_d;
    logic [12:0]         pat_addr_q, pat_addr_d;
    logic [31:0]         rend_buf_q, rend_buf_d;
    logic [N_SLOTS-1:0]  rend_load_q, rend_load_d;
    logic [N_SLOTS-1:0]  spr_valid_q, spr_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                   scan_done_s;
    logic [3:0]             hit_cnt_s;
    spr_ent_t [N_SLOTS-1:0] list_s;
    spr_ent_t               ent_s;
    spr_ent_t               ent_nx_s;
    logic                   used_s;
    logic                   used_nx_s;
    logic                   ack_ok_s;

    spr_scan u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (line_start),
        .line_in   (next_line),
        .oam_addr  (oam_addr),
        .oam_data  (oam_data),
        .scan_done (scan_done_s),
        .hit_cnt   (hit_cnt_s),
        .list      (list_s),
        .overflow  (overflow)
    );

    assign ent_s     = list_s[slot_q];
    assign ent_nx_s  = list_s[slot_d];
    assign used_s    = ({1'b0, slot_q} < hit_cnt_s);
    assign used_nx_s = ({1'b0, slot_d} < hit_cnt_s);
    // An ack only counts against a request we are still holding.
    assign ack_ok_s  = pat_ack && pat_req_q;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= 3'd0;
            lo_q        <= 8'd0;
            sel_q       <= 1'b0;
            pat_req_q   <= 1'b0;
            pat_addr_q  <= 13'd0;
            rend_buf_q  <= 32'd0;
            rend_load_q <= '0;
            spr_valid_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            lo_q        <= lo_d;
            sel_q       <= sel_d;
            pat_req_q   <= pat_req_d;
            pat_addr_q  <= pat_addr_d;
            rend_buf_q  <= rend_buf_d;
            rend_load_q <= rend_load_d;
            spr_valid_q <= spr_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state: a new line_start always wins, including over a same-cycle ack.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (line_start) begin
            state_d = ST_SCAN_Y;
            slot_d  = 3'd0;
        end else begin
            case (state_q)
                ST_SCAN_Y: begin
                    if (scan_done_s) begin
                        state_d = ST_FETCH_LO;
                    end else begin
                        state_d = ST_SCAN_Y;
                    end
                end
                ST_FETCH_LO: begin
                    if (!used_s) begin
                        state_d = ST_LOAD;
                    end else if (ack_ok_s) begin
                        state_d = ST_FETCH_HI;
                    end else begin
                        state_d = ST_FETCH_LO;
                    end
                end
                ST_FETCH_HI: begin
                    if (ack_ok_s) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_FETCH_HI;
                    end
                end
                ST_LOAD: begin
                    if (slot_q == 3'(N_SLOTS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        slot_d  = slot_q + 3'd1;
                        state_d = ST_FETCH_LO;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode, registered so every port changes only on a clock edge.
    always_comb begin
        sel_d       = line_start ? pat_sel : sel_q;
        lo_d        = lo_q;
        rend_buf_d  = rend_buf_q;
        rend_load_d = '0;
        spr_valid_d = spr_valid_q;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);

        if ((state_d == ST_FETCH_LO) && used_nx_s) begin
            pat_req_d  = 1'b1;
            pat_addr_d = {sel_q, ent_nx_s.tile, 1'b0, ent_nx_s.row};
        end else if (state_d == ST_FETCH_HI) begin
            pat_req_d  = 1'b1;
            pat_addr_d = {sel_q, ent_nx_s.tile, 1'b1, ent_nx_s.row};
        end else begin
            pat_req_d  = 1'b0;
            pat_addr_d = 13'd0;
        end

        if (line_start) begin
            spr_valid_d = '0;
        end else if ((state_q == ST_FETCH_LO) && used_s && ack_ok_s) begin
            lo_d = pat_data;
        end else if ((state_q == ST_FETCH_HI) && ack_ok_s) begin
            rend_buf_d          = pack_word(ent_s, lo_q, pat_data);
            rend_load_d[slot_q] = 1'b1;
            spr_valid_d[slot_q] = 1'b1;
        end else if ((state_q == ST_FETCH_LO) && !used_s) begin
            rend_buf_d          = EMPTY_WORD;
            rend_load_d[slot_q] = 1'b1;
        end else begin
            lo_d = lo_q;
        end
    end

    assign pat_req   = pat_req_q;
    assign pat_addr  = pat_addr_q;
    assign rend_buf  = rend_buf_q;
    assign rend_load = rend_load_q;
    assign spr_valid = spr_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_spr_fetch.sv
// Directed bench for spr_fetch: OAM and pattern memory models, one task per scenario.
module tb_spr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_start;
    logic [7:0]  next_line;
    logic        pat_sel;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        pat_req;
    logic [12:0] pat_addr;
    logic        pat_ack;
    logic [7:0]  pat_data;
    logic [31:0] rend_buf;
    logic [7:0]  rend_load;
    logic [7:0]  spr_valid;
    logic        busy;
    logic        done;
    logic        overflow;

`ifdef SPR_OVF_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic [7:0]  oam_mem [0:255];
    logic [7:0]  pat_mem [0:8191];
    logic        ack_r, ack_en, inj_ack;
    logic [7:0]  pdata_r;
    int          lat;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] got_buf [0:7];
    logic [12:0] addr_log [0:31];
    int          load_cnt, multi_hot, done_cnt, req_cnt;

    always #5 clk = ~clk;

    spr_fetch dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .next_line(next_line),
        .pat_sel(pat_sel), .oam_addr(oam_addr), .oam_data(oam_data), .pat_req(pat_req),
        .pat_addr(pat_addr), .pat_ack(pat_ack), .pat_data(pat_data), .rend_buf(rend_buf),
        .rend_load(rend_load), .spr_valid(spr_valid), .busy(busy), .done(done),
        .overflow(overflow)
    );

    // OAM: synchronous read, data one cycle behind address.
    always @(posedge clk) oam_data <= oam_mem[oam_addr];

    // Pattern memory: ack two cycles after a request is seen.
    always @(posedge clk) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
            lat   <= 0;
        end else if (pat_req && !ack_r && ack_en) begin
            if (lat == 1) begin
                ack_r   <= 1'b1;
                pdata_r <= pat_mem[pat_addr];
                lat     <= 0;
            end else begin
                lat <= lat + 1;
            end
        end else begin
            ack_r <= 1'b0;
            lat   <= 0;
        end
    end
    assign pat_ack  = ack_r | inj_ack;
    assign pat_data = pdata_r;

    always @(negedge clk) begin
        if (rend_load != 8'h00) begin
            if ($countones(rend_load) != 1) multi_hot++;
            for (int k = 0; k < 8; k++) if (rend_load[k]) got_buf[k] = rend_buf;
            load_cnt++;
        end
        if (done) done_cnt++;
        if (pat_req && pat_ack) begin
            if (req_cnt < 32) addr_log[req_cnt] = pat_addr;
            req_cnt++;
        end
    end

    function automatic logic [31:0] exp_word(input logic [7:0] a, input logic [7:0] x,
                                             input logic [7:0] lo, input logic [7:0] hi);
        return {1'b0, a[6], a[5], 3'b000, a[1:0], x, hi, lo};
    endfunction

    task automatic clear_log();
        load_cnt = 0; multi_hot = 0; done_cnt = 0; req_cnt = 0;
        for (int k = 0; k < 8; k++) got_buf[k] = 32'hDEAD_BEEF;
    endtask

    task automatic hide_all();
        for (int i = 0; i < 64; i++) begin
            oam_mem[4*i] = 8'hF8; oam_mem[4*i+1] = 8'h00;
            oam_mem[4*i+2] = 8'h00; oam_mem[4*i+3] = 8'h00;
        end
    endtask

    task automatic set_ent(input int i, input logic [7:0] y, input logic [7:0] t,
                           input logic [7:0] a, input logic [7:0] x);
        oam_mem[4*i] = y; oam_mem[4*i+1] = t; oam_mem[4*i+2] = a; oam_mem[4*i+3] = x;
    endtask

    task automatic start_line(input logic [7:0] ln, input logic sel);
        clear_log();
        @(negedge clk);
        next_line = ln; pat_sel = sel; line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            @(negedge clk); #1;
        end
        tests++;
        if (done_cnt == 0) begin
            fails++; $display("FAIL %s_timeout: done never seen", name);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; line_start = 1'b0; next_line = 8'd0; pat_sel = 1'b0;
        ack_en = 1'b1; inj_ack = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({pat_req, pat_addr, rend_buf, rend_load, spr_valid, busy, done, overflow, oam_addr} !== 72'd0) begin
            fails++; $display("FAIL reset_outputs: got nonzero outputs, required all zero");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        hide_all(); set_ent(0, 8'd10, 8'd3, 8'h41, 8'd20);
        pat_mem[13'h032] = 8'h40; pat_mem[13'h03A] = 8'h81;
        start_line(8'd12, 1'b0);
        wait_done("basic");
        tests++; if (req_cnt !== 2) begin fails++; $display("FAIL basic_req_cnt: got %0d required 2", req_cnt); end
        tests++; if (addr_log[0] !== 13'h032) begin fails++; $display("FAIL basic_addr_lo: got %h required 032", addr_log[0]); end
        tests++; if (addr_log[1] !== 13'h03A) begin fails++; $display("FAIL basic_addr_hi: got %h required 03a", addr_log[1]); end
        tests++; if (got_buf[0] !== 32'h4114_8140) begin fails++; $display("FAIL basic_slot0: got %h required 41148140", got_buf[0]); end
        for (int k = 1; k < 8; k++) begin
            tests++; if (got_buf[k] !== 32'h00FF_0000) begin fails++; $display("FAIL basic_empty_slot%0d: got %h required 00ff0000", k, got_buf[k]); end
        end
        tests++; if (spr_valid !== 8'h01) begin fails++; $display("FAIL basic_valid: got %h required 01", spr_valid); end
        tests++; if (load_cnt !== 8 || multi_hot !== 0) begin fails++; $display("FAIL basic_loads: got %0d/%0d required 8/0", load_cnt, multi_hot); end
        tests++; if (done_cnt !== 1 || busy !== 1'b0) begin fails++; $display("FAIL basic_done: got %0d busy %b required 1 busy 0", done_cnt, busy); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %b required 0", overflow); end
    endtask

    task automatic test_vflip();
        hide_all(); set_ent(0, 8'd10, 8'd5, 8'h80, 8'd30);
        pat_mem[13'h1056] = 8'h12; pat_mem[13'h105E] = 8'h34;
        start_line(8'd11, 1'b1);
        wait_done("vflip");
        tests++; if (addr_log[0] !== 13'h1056 || addr_log[1] !== 13'h105E) begin fails++; $display("FAIL vflip_addr: got %h %h required 1056 105e", addr_log[0], addr_log[1]); end
        tests++; if (got_buf[0] !== 32'h001E_3412) begin fails++; $display("FAIL vflip_slot0: got %h required 001e3412", got_buf[0]); end
        tests++; if (spr_valid !== 8'h01) begin fails++; $display("FAIL vflip_valid: got %h required 01", spr_valid); end
    endtask

    task automatic test_multi();
        logic [7:0] a, t;
        logic [3:0] iv;
        hide_all();
        for (int i = 0; i < 10; i++) begin
            iv = i[3:0];
            set_ent(i, 8'd0, 8'h20 + 8'(i), {1'b0, iv[1], iv[2], 3'b000, iv[1:0]}, 8'(8*i + 1));
        end
        start_line(8'd3, 1'b0);
        wait_done("multi");
        for (int k = 0; k < 8; k++) begin
            iv = k[3:0];
            t = 8'h20 + 8'(k);
            a = {1'b0, iv[1], iv[2], 3'b000, iv[1:0]};
            tests++;
            if (got_buf[k] !== exp_word(a, 8'(8*k + 1), pat_mem[{1'b0, t, 1'b0, 3'd3}], pat_mem[{1'b0, t, 1'b1, 3'd3}])) begin
                fails++; $display("FAIL multi_slot%0d: got %h", k, got_buf[k]);
            end
        end
        tests++; if (spr_valid !== 8'hFF) begin fails++; $display("FAIL multi_valid: got %h required ff", spr_valid); end
        tests++; if (req_cnt !== 16) begin fails++; $display("FAIL multi_req_cnt: got %0d required 16", req_cnt); end
        tests++; if (overflow !== EXP_OVF) begin fails++; $display("FAIL multi_ovf: got %b required %b", overflow, EXP_OVF); end
    endtask

    task automatic test_hidden();
        hide_all(); set_ent(0, 8'hF5, 8'd1, 8'h00, 8'h40);
        start_line(8'hF8, 1'b0);
        wait_done("hidden");
        tests++; if (load_cnt !== 8 || multi_hot !== 0) begin fails++; $display("FAIL hidden_loads: got %0d/%0d required 8/0", load_cnt, multi_hot); end
        for (int k = 0; k < 8; k++) begin
            tests++; if (got_buf[k] !== 32'h00FF_0000) begin fails++; $display("FAIL hidden_slot%0d: got %h required 00ff0000", k, got_buf[k]); end
        end
        tests++; if (spr_valid !== 8'h00 || req_cnt !== 0) begin fails++; $display("FAIL hidden_valid: got %h req %0d required 00 req 0", spr_valid, req_cnt); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL hidden_ovf: got %b required 0 after new line", overflow); end
    endtask

    task automatic test_boundary();
        hide_all();
        set_ent(0, 8'h10, 8'h06, 8'h00, 8'h50);
        set_ent(1, 8'h11, 8'h07, 8'h03, 8'h60);
        set_ent(2, 8'hEF, 8'h08, 8'h00, 8'h70);
        start_line(8'h18, 1'b0);
        wait_done("boundary");
        tests++; if (req_cnt !== 2 || addr_log[0] !== 13'h077 || addr_log[1] !== 13'h07F) begin fails++; $display("FAIL boundary_addr: got %0d %h %h required 2 077 07f", req_cnt, addr_log[0], addr_log[1]); end
        tests++; if (got_buf[0] !== exp_word(8'h03, 8'h60, pat_mem[13'h077], pat_mem[13'h07F])) begin fails++; $display("FAIL boundary_slot0: got %h", got_buf[0]); end
        tests++; if (spr_valid !== 8'h01) begin fails++; $display("FAIL boundary_valid: got %h required 01", spr_valid); end
    endtask

    task automatic test_abort();
        hide_all(); set_ent(0, 8'd10, 8'd3, 8'h41, 8'd20);
        ack_en = 1'b0;
        start_line(8'd12, 1'b0);
        for (int i = 0; i < 1000 && !pat_req; i++) @(negedge clk);
        tests++; if (pat_req !== 1'b1) begin fails++; $display("FAIL abort_req_wait: got %b required 1", pat_req); end
        @(negedge clk);
        line_start = 1'b1; inj_ack = 1'b1;
        @(negedge clk);
        line_start = 1'b0; inj_ack = 1'b0;
        #1;
        tests++; if (pat_req !== 1'b0 || spr_valid !== 8'h00) begin fails++; $display("FAIL abort_drop: got req %b valid %h required 0 00", pat_req, spr_valid); end
        clear_log();
        repeat (3) @(negedge clk);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        ack_en = 1'b1;
        wait_done("abort");
        tests++; if (load_cnt !== 8 || req_cnt !== 2 || addr_log[0] !== 13'h032) begin fails++; $display("FAIL abort_rescan: got %0d %0d %h required 8 2 032", load_cnt, req_cnt, addr_log[0]); end
        tests++; if (got_buf[0] !== 32'h4114_8140) begin fails++; $display("FAIL abort_slot0: got %h required 41148140", got_buf[0]); end
    endtask

    task automatic test_reset_mid();
        hide_all(); set_ent(0, 8'd10, 8'd3, 8'h41, 8'd20);
        start_line(8'd12, 1'b0);
        for (int i = 0; i < 1000 && req_cnt == 0; i++) begin @(negedge clk); #1; end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({pat_req, pat_addr, rend_buf, rend_load, spr_valid, busy, done, overflow, oam_addr} !== 72'd0) begin
            fails++; $display("FAIL rstmid_outputs: got nonzero outputs, required all zero");
        end
        repeat (4) @(negedge clk);
        tests++; if (load_cnt !== 0) begin fails++; $display("FAIL rstmid_noload: got %0d required 0", load_cnt); end
        rst_n = 1'b1;
        start_line(8'd12, 1'b0);
        wait_done("rstmid");
        tests++; if (got_buf[0] !== 32'h4114_8140 || load_cnt !== 8) begin fails++; $display("FAIL rstmid_restart: got %h %0d required 41148140 8", got_buf[0], load_cnt); end
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) pat_mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'hA5;
        hide_all();
        clear_log();
        test_reset();
        test_basic();
        test_vflip();
        test_multi();
        test_hidden();
        test_boundary();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
